// File: rtl/ralu_pkg.sv
// -----------------------------------------------------------------------------
// ralu_pkg
// Shared definitions for the RALU arbiter slice: datapath widths, the NOP
// control word, control-word field offsets and the arbiter state encoding.
//
// Control word layout (CW_W = 17):
//   S[16:13] M[12] Pin[11] ISR[10] ISL[9] A[8] wr[7] adr[6:4] v[3:0]
// -----------------------------------------------------------------------------
package ralu_pkg;

    localparam int CW_W = 17;
    localparam int D_W  = 4;

    // All-zero word: no write, no shift, nothing latched in the RALU.
    localparam logic [CW_W-1:0] CW_NOP = '0;

    // Control-word field offsets.
    localparam int CW_S_LSB   = 13;
    localparam int CW_M_BIT   = 12;
    localparam int CW_PIN_BIT = 11;
    localparam int CW_ISR_BIT = 10;
    localparam int CW_ISL_BIT = 9;
    localparam int CW_A_BIT   = 8;
    localparam int CW_WR_BIT  = 7;
    localparam int CW_ADR_LSB = 4;
    localparam int CW_V_LSB   = 0;

    // Idle-timeout: the grant is revoked on the 15th consecutive idle cycle,
    // i.e. when the counter already holds 14 and another idle cycle arrives.
    localparam logic [3:0] IDLE_REVOKE_AT = 4'd14;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin priority encoder. Searches req_i starting at
// ptr_i and wrapping modulo N; returns the first hit as one-hot and index.
//
// Ports:
//   req_i     N      request vector
//   ptr_i     IDX_W  search start position (0..N-1)
//   onehot_o  N      one-hot winner (zero when no request)
//   idx_o     IDX_W  winner index (zero when no request)
//   any_o     1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic [N-1:0]     onehot_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);

    logic [IDX_W-1:0] cand;
    logic             found;

    // NOTE: every output of a combinational block gets a default before any
    // conditional assignment, otherwise the tool infers a latch to hold it.
    always_comb begin
        onehot_o = '0;
        idx_o    = '0;
        found    = 1'b0;
        cand     = '0;
        for (int i = 0; i < N; i++) begin
            cand = IDX_W'((int'(ptr_i) + i) % N);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                idx_o           = cand;
                onehot_o[cand]  = 1'b1;
            end
        end
        any_o = found;
    end

endmodule

// File: rtl/ralu_arbiter.sv
// -----------------------------------------------------------------------------
// ralu_arbiter
// Round-robin arbiter sharing one RALU between N_REQ microprogram requesters.
// A winner owns the RALU for a locked burst of control words ending with a
// `last` beat. Each beat is registered onto ralu_cw; one cycle later the RALU
// result is captured and returned to the beat's owner with a one-cycle strobe.
//
// Optional feature (macro RALU_ARB_TIMEOUT_EN): revoke a grant after 15
// consecutive idle burst cycles. Without the macro a grant is held until last.
//
// Ports:
//   clock      in   rising-edge clock
//   reset      in   synchronous active-high reset
//   req        in   per-requester burst request / beat valid
//   last       in   final beat of the burst (qualified by req)
//   cw         in   packed control words, requester k at [k*CW_W +: CW_W]
//   gnt        out  one-hot ownership (registered)
//   ralu_cw    out  control bus to the RALU (registered, NOP when idle)
//   ralu_r     in   RALU result
//   ralu_pout  in   RALU carry out
//   rsp_valid  out  one-hot response strobe
//   rsp_data   out  captured result
//   rsp_carry  out  captured carry
//   rsp_zero   out  captured result == 0
//   busy       out  a grant is held
// -----------------------------------------------------------------------------
module ralu_arbiter
    import ralu_pkg::*;
#(
    parameter int N_REQ = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ-1:0]      last,
    input  logic [N_REQ*CW_W-1:0] cw,
    output logic [N_REQ-1:0]      gnt,
    output logic [CW_W-1:0]       ralu_cw,
    input  logic [D_W-1:0]        ralu_r,
    input  logic                  ralu_pout,
    output logic [N_REQ-1:0]      rsp_valid,
    output logic [D_W-1:0]        rsp_data,
    output logic                  rsp_carry,
    output logic                  rsp_zero,
    output logic                  busy
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e       state_q, state_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] owner_q, owner_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [CW_W-1:0]  cw_q, cw_d;

    // Beat currently on ralu_cw, tagged with its owner so the response can
    // still be routed after the grant has dropped.
    logic             beat_vld_q, beat_vld_d;
    logic [IDX_W-1:0] beat_tag_q, beat_tag_d;

    logic [N_REQ-1:0] rsp_valid_q, rsp_valid_d;
    logic [D_W-1:0]   rsp_data_q, rsp_data_d;
    logic             rsp_carry_q, rsp_carry_d;
    logic             rsp_zero_q, rsp_zero_d;

`ifdef RALU_ARB_TIMEOUT_EN
    logic [3:0]       idle_cnt_q, idle_cnt_d;
`endif

    logic [N_REQ-1:0] pick_onehot;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;
    logic [CW_W-1:0]  cw_arr [N_REQ];
    logic             beat;

    for (genvar k = 0; k < N_REQ; k++) begin : g_cw
        assign cw_arr[k] = cw[k*CW_W +: CW_W];
    end

    rr_pick #(
        .N     (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req_i    (req),
        .ptr_i    (ptr_q),
        .onehot_o (pick_onehot),
        .idx_o    (pick_idx),
        .any_o    (pick_any)
    );

    // A beat is the owner's req during a burst; other requesters are ignored.
    assign beat = (state_q == ARB_BURST) && req[owner_q];

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        owner_d    = owner_q;
        gnt_d      = gnt_q;
        cw_d       = CW_NOP;
        beat_vld_d = 1'b0;
        beat_tag_d = owner_q;
`ifdef RALU_ARB_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
`endif

        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d = ARB_BURST;
                    gnt_d   = pick_onehot;
                    owner_d = pick_idx;
                    ptr_d   = (pick_idx == IDX_W'(N_REQ - 1)) ? '0 : pick_idx + IDX_W'(1);
`ifdef RALU_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ARB_BURST: begin
                if (beat) begin
                    cw_d       = cw_arr[owner_q];
                    beat_vld_d = 1'b1;
`ifdef RALU_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (last[owner_q]) begin
                        state_d = ARB_IDLE;
                        gnt_d   = '0;
                    end
                end else begin
`ifdef RALU_ARB_TIMEOUT_EN
                    // Revocation keeps the pointer, which already moved past
                    // the owner at grant time.
                    if (idle_cnt_q == IDLE_REVOKE_AT) begin
                        state_d    = ARB_IDLE;
                        gnt_d      = '0;
                        idle_cnt_d = '0;
                    end else begin
                        idle_cnt_d = idle_cnt_q + 4'd1;
                    end
`endif
                end
            end
            default: state_d = ARB_IDLE;
        endcase

        // Response stage: sample the RALU one cycle after the beat was driven.
        rsp_valid_d = '0;
        rsp_data_d  = rsp_data_q;
        rsp_carry_d = rsp_carry_q;
        rsp_zero_d  = rsp_zero_q;
        if (beat_vld_q) begin
            rsp_valid_d[beat_tag_q] = 1'b1;
            rsp_data_d              = ralu_r;
            rsp_carry_d             = ralu_pout;
            rsp_zero_d              = ~|ralu_r;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ARB_IDLE;
            ptr_q       <= '0;
            owner_q     <= '0;
            gnt_q       <= '0;
            cw_q        <= CW_NOP;
            beat_vld_q  <= 1'b0;
            beat_tag_q  <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            rsp_carry_q <= 1'b0;
            rsp_zero_q  <= 1'b0;
`ifdef RALU_ARB_TIMEOUT_EN
            idle_cnt_q  <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            owner_q     <= owner_d;
            gnt_q       <= gnt_d;
            cw_q        <= cw_d;
            beat_vld_q  <= beat_vld_d;
            beat_tag_q  <= beat_tag_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_carry_q <= rsp_carry_d;
            rsp_zero_q  <= rsp_zero_d;
`ifdef RALU_ARB_TIMEOUT_EN
            idle_cnt_q  <= idle_cnt_d;
`endif
        end
    end

    assign gnt       = gnt_q;
    assign ralu_cw   = cw_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_carry = rsp_carry_q;
    assign rsp_zero  = rsp_zero_q;
    assign busy      = (state_q == ARB_BURST);

endmodule

// File: tb/tb_ralu_arbiter.sv
// -----------------------------------------------------------------------------
// tb_ralu_arbiter
// Self-checking bench for ralu_arbiter (N_REQ = 4). Stimulus is cycle-based;
// every issued beat pushes its expected response (owner, data, carry, zero,
// due cycle) to a scoreboard that a negedge monitor pops and compares.
// The timeout section follows RALU_ARB_TIMEOUT_EN as seen by the RTL.
// -----------------------------------------------------------------------------
module tb_ralu_arbiter;
    import ralu_pkg::*;

    localparam int N = 4;

    logic              clock;
    logic              reset;
    logic [N-1:0]      req;
    logic [N-1:0]      last;
    logic [CW_W-1:0]   cw_v [N];
    logic [N*CW_W-1:0] cw_bus;
    logic [N-1:0]      gnt;
    logic [CW_W-1:0]   ralu_cw;
    logic [D_W-1:0]    ralu_r;
    logic              ralu_pout;
    logic [N-1:0]      rsp_valid;
    logic [D_W-1:0]    rsp_data;
    logic              rsp_carry;
    logic              rsp_zero;
    logic              busy;

    // Stand-in RALU: either a constant, or R = v field and Pout = S[3] of the
    // word on the control bus.
    logic              use_model;
    logic [D_W-1:0]    r_const;
    logic              p_const;

    assign cw_bus    = {cw_v[3], cw_v[2], cw_v[1], cw_v[0]};
    assign ralu_r    = use_model ? ralu_cw[3:0] : r_const;
    assign ralu_pout = use_model ? ralu_cw[16] : p_const;

    ralu_arbiter #(.N_REQ(N)) dut (
        .clock     (clock),
        .reset     (reset),
        .req       (req),
        .last      (last),
        .cw        (cw_bus),
        .gnt       (gnt),
        .ralu_cw   (ralu_cw),
        .ralu_r    (ralu_r),
        .ralu_pout (ralu_pout),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_carry (rsp_carry),
        .rsp_zero  (rsp_zero),
        .busy      (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    int cyc_cnt  = 0;
    logic mon_en = 1'b0;
    logic [N-1:0] cur_gnt;

    always @(posedge clock) cyc_cnt <= cyc_cnt + 1;

    typedef struct {
        logic [N-1:0]   vld;
        logic [D_W-1:0] data;
        logic           carry;
        logic           zero;
        int             due;
    } rsp_t;

    rsp_t sb[$];

    typedef struct {
        logic [N-1:0]    req;
        logic [N-1:0]    last;
        logic [N-1:0]    gnt;
        logic [CW_W-1:0] cw;
    } vec_t;

    vec_t tbl [12];

    localparam logic [CW_W-1:0] CW0 = 17'h1_0000;
    localparam logic [CW_W-1:0] CW1 = 17'h0_0015;
    localparam logic [CW_W-1:0] CW2 = 17'h1_00AA;
    localparam logic [CW_W-1:0] CW3 = 17'h0_333F;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc_cnt);
        end
    endtask

    // Response monitor, sampled on the falling edge.
    always @(negedge clock) begin
        rsp_t e;
        if (mon_en) begin
            while (sb.size() != 0 && sb[0].due < cyc_cnt) begin
                e = sb.pop_front();
                check("rsp_missed", 32'(e.due), 32'(cyc_cnt));
            end
            if (sb.size() != 0 && sb[0].due == cyc_cnt) begin
                e = sb.pop_front();
                check("rsp_valid", 32'(rsp_valid), 32'(e.vld));
                check("rsp_data",  32'(rsp_data),  32'(e.data));
                check("rsp_carry", 32'(rsp_carry), 32'(e.carry));
                check("rsp_zero",  32'(rsp_zero),  32'(e.zero));
            end else begin
                check("rsp_quiet", 32'(rsp_valid), 32'(0));
            end
        end
    end

    // One clock cycle: drive req/last, predict a response if the expected
    // owner presents a beat, then check the registered outputs after the edge.
    task automatic cyc(input logic [N-1:0] r, input logic [N-1:0] l,
                       input logic [N-1:0] eg, input logic [CW_W-1:0] ecw,
                       input string nm);
        rsp_t e;
        req  = r;
        last = l;
        for (int k = 0; k < N; k++) begin
            if (cur_gnt[k] && r[k]) begin
                e.vld   = N'(1 << k);
                e.data  = use_model ? cw_v[k][3:0] : r_const;
                e.carry = use_model ? cw_v[k][16] : p_const;
                e.zero  = (e.data == '0);
                e.due   = cyc_cnt + 2;
                sb.push_back(e);
            end
        end
        @(posedge clock);
        #1;
        check({nm, "_gnt"},  32'(gnt),     32'(eg));
        check({nm, "_cw"},   32'(ralu_cw), 32'(ecw));
        check({nm, "_busy"}, 32'(busy),    32'(eg != '0));
        cur_gnt = eg;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req   = '0;
        last  = '0;
        sb.delete();
        cur_gnt = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        req       = '0;
        last      = '0;
        use_model = 1'b1;
        r_const   = '0;
        p_const   = 1'b0;
        cur_gnt   = '0;
        for (int k = 0; k < N; k++) cw_v[k] = CW_NOP;

        tbl[0]  = '{4'b1111, 4'b1111, 4'b0001, CW_NOP};
        tbl[1]  = '{4'b1111, 4'b1111, 4'b0000, CW0};
        tbl[2]  = '{4'b1111, 4'b1111, 4'b0010, CW_NOP};
        tbl[3]  = '{4'b1111, 4'b1111, 4'b0000, CW1};
        tbl[4]  = '{4'b1111, 4'b1111, 4'b0100, CW_NOP};
        tbl[5]  = '{4'b1111, 4'b1111, 4'b0000, CW2};
        tbl[6]  = '{4'b1111, 4'b1111, 4'b1000, CW_NOP};
        tbl[7]  = '{4'b1111, 4'b1111, 4'b0000, CW3};
        tbl[8]  = '{4'b1111, 4'b1111, 4'b0001, CW_NOP};
        tbl[9]  = '{4'b1111, 4'b1111, 4'b0000, CW0};
        tbl[10] = '{4'b0000, 4'b0000, 4'b0000, CW_NOP};
        tbl[11] = '{4'b0000, 4'b0000, 4'b0000, CW_NOP};

        do_reset();
        mon_en = 1'b1;

        // Reset state.
        check("rst_gnt",       32'(gnt),       32'(0));
        check("rst_ralu_cw",   32'(ralu_cw),   32'(CW_NOP));
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_data",  32'(rsp_data),  32'(0));
        check("rst_rsp_carry", 32'(rsp_carry), 32'(0));
        check("rst_rsp_zero",  32'(rsp_zero),  32'(0));
        check("rst_busy",      32'(busy),      32'(0));

        // Single requester 0, 3-beat burst, RALU returns R=0 / Pout=1.
        use_model = 1'b0;
        r_const   = 4'h0;
        p_const   = 1'b1;
        cyc(4'b0001, 4'b0000, 4'b0001, CW_NOP, "b3_grant");
        cw_v[0] = 17'h1_2345;
        cyc(4'b0001, 4'b0000, 4'b0001, 17'h1_2345, "b3_beat0");
        cw_v[0] = 17'h0_0F0F;
        cyc(4'b0001, 4'b0000, 4'b0001, 17'h0_0F0F, "b3_beat1");
        cw_v[0] = 17'h0_00A1;
        cyc(4'b0001, 4'b0001, 4'b0000, 17'h0_00A1, "b3_last");
        cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "b3_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "b3_drain");

        // All four requesting single-beat bursts: table-driven.
        do_reset();
        use_model = 1'b1;
        cw_v[0] = CW0;
        cw_v[1] = CW1;
        cw_v[2] = CW2;
        cw_v[3] = CW3;
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].req, tbl[i].last, tbl[i].gnt, tbl[i].cw, $sformatf("rr%0d", i));
        end

        // Owner 2 stalls 3 cycles; requester 0 waits despite req/last.
        do_reset();
        cw_v[2] = 17'h0_1234;
        cyc(4'b0100, 4'b0000, 4'b0100, CW_NOP, "st_grant");
        cyc(4'b0101, 4'b0000, 4'b0100, 17'h0_1234, "st_beat");
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0001, 4'b0001, 4'b0100, CW_NOP, "st_idle");
        end
        cw_v[2] = 17'h1_0009;
        cyc(4'b0101, 4'b0100, 4'b0000, 17'h1_0009, "st_last");
        cw_v[0] = 17'h0_0070;
        cyc(4'b0001, 4'b0000, 4'b0001, CW_NOP, "st_next");
        cyc(4'b0001, 4'b0001, 4'b0000, 17'h0_0070, "st_next_last");
        cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "st_drain");
        cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "st_drain");

        // Reset the cycle after a beat was issued: response discarded.
        do_reset();
        cw_v[0] = 17'h0_0005;
        cyc(4'b0001, 4'b0000, 4'b0001, CW_NOP, "mr_grant");
        cyc(4'b0001, 4'b0000, 4'b0001, 17'h0_0005, "mr_beat");
        reset   = 1'b1;
        req     = '0;
        sb.delete();
        cur_gnt = '0;
        @(posedge clock);
        #1;
        check("mr_gnt",       32'(gnt),       32'(0));
        check("mr_ralu_cw",   32'(ralu_cw),   32'(CW_NOP));
        check("mr_busy",      32'(busy),      32'(0));
        check("mr_rsp_valid", 32'(rsp_valid), 32'(0));
        @(posedge clock);
        #1;
        check("mr_rsp_valid2", 32'(rsp_valid), 32'(0));
        reset = 1'b0;

        // Idle owner: timeout revokes, otherwise the grant is held.
        do_reset();
        cw_v[1] = 17'h0_0003;
        cw_v[2] = 17'h0_0008;
        cyc(4'b0010, 4'b0000, 4'b0010, CW_NOP, "to_grant");
`ifdef RALU_ARB_TIMEOUT_EN
        for (int i = 0; i < 14; i++) begin
            cyc(4'b0000, 4'b0000, 4'b0010, CW_NOP, "to_hold");
        end
        cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "to_revoke");
        cyc(4'b1111, 4'b0000, 4'b0100, CW_NOP, "to_ptr");
        cyc(4'b0100, 4'b0100, 4'b0000, 17'h0_0008, "to_end");
`else
        for (int i = 0; i < 40; i++) begin
            cyc(4'b0000, 4'b0000, 4'b0010, CW_NOP, "to_hold");
        end
        cyc(4'b0010, 4'b0010, 4'b0000, 17'h0_0003, "to_end");
`endif
        for (int i = 0; i < 3; i++) begin
            cyc(4'b0000, 4'b0000, 4'b0000, CW_NOP, "to_drain");
        end

        check("sb_empty", 32'(sb.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
